// File: rtl/and_gate.sv
// and_gate: bitwise two-input AND with a registered, valid-qualified copy of
// the result plus status (all-ones, any-one, popcount, saturating match count).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   a, b           operands (WIDTH bits)
//   c              combinational a & b (zero latency, unaffected by reset)
//   in_valid       capture a/b on this edge
//   clr            synchronous clear of match_cnt (wins over increment)
//   c_q            registered a & b (holds when in_valid=0)
//   out_valid      high for one cycle after each capture
//   all_ones       registered &(a & b)
//   any_one        registered |(a & b)
//   pop            registered popcount of (a & b)
//   match_cnt      saturating count of captures whose result was all ones
module and_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic [WIDTH-1:0]           c,
  input  logic                       in_valid,
  input  logic                       clr,
  output logic [WIDTH-1:0]           c_q,
  output logic                       out_valid,
  output logic                       all_ones,
  output logic                       any_one,
  output logic [$clog2(WIDTH+1)-1:0] pop,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int unsigned POP_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] and_v;

  logic [WIDTH-1:0] res_q,   res_d;
  logic             vld_q,   vld_d;
  logic             all_q,   all_d;
  logic             any_q,   any_d;
  logic [POP_W-1:0] pop_q,   pop_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Combinational glue output; 4-state AND so 0&x=0 and 1&x=x.
  assign and_v = a & b;
  assign c     = and_v;

  // Next-state: capture on in_valid, otherwise hold; counter saturates at all-ones.
  always_comb begin
    res_d = res_q;
    all_d = all_q;
    any_d = any_q;
    pop_d = pop_q;
    vld_d = in_valid;
    cnt_d = cnt_q;

    if (in_valid) begin
      res_d = and_v;
      all_d = &and_v;
      any_d = |and_v;
      pop_d = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        pop_d = pop_d + POP_W'(and_v[i]);
      end
    end

    if (clr) begin
      cnt_d = '0;
    end else if (in_valid && (&and_v) && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
      all_q <= 1'b0;
      any_q <= 1'b0;
      pop_q <= '0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
      all_q <= all_d;
      any_q <= any_d;
      pop_q <= pop_d;
      cnt_q <= cnt_d;
    end
  end

  assign c_q       = res_q;
  assign out_valid = vld_q;
  assign all_ones  = all_q;
  assign any_one   = any_q;
  assign pop       = pop_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_and_gate.sv
// Testbench for and_gate: one WIDTH=8/CNT_W=2 instance and one WIDTH=1/CNT_W=16
// instance driven in lockstep, checked against a behavioural model.
module tb_and_gate;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       clr;

  logic [7:0] a8, b8, c8, c_q8;
  logic       ov8, all8, any8;
  logic [3:0] pop8;
  logic [1:0] cnt8;

  logic       a1, b1, c1, c_q1;
  logic       ov1, all1, any1;
  logic [0:0] pop1;
  logic [15:0] cnt1;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [7:0] m8_cq;
  logic       m8_v;
  int         m8_cnt;
  logic       m1_cq;
  logic       m1_v;
  int         m1_cnt;

  and_gate #(.WIDTH(8), .CNT_W(2)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8),
    .in_valid(in_valid), .clr(clr), .c_q(c_q8), .out_valid(ov8),
    .all_ones(all8), .any_one(any8), .pop(pop8), .match_cnt(cnt8)
  );

  and_gate #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1),
    .in_valid(in_valid), .clr(clr), .c_q(c_q1), .out_valid(ov1),
    .all_ones(all1), .any_one(any1), .pop(pop1), .match_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m8_cq = '0; m8_v = 1'b0; m8_cnt = 0;
    m1_cq = 1'b0; m1_v = 1'b0; m1_cnt = 0;
  endtask

  task automatic model_step(input logic [7:0] av, input logic [7:0] bv,
                            input logic vld, input logic cl);
    if (vld) begin
      m8_cq = av & bv;
      m1_cq = av[0] & bv[0];
    end
    m8_v = vld;
    m1_v = vld;
    if (cl) begin
      m8_cnt = 0;
      m1_cnt = 0;
    end else if (vld) begin
      if ((av & bv) == 8'hFF && m8_cnt < 3)     m8_cnt++;
      if ((av[0] & bv[0]) && m1_cnt < 65535)    m1_cnt++;
    end
  endtask

  task automatic check_regs();
    chk("c_q8",  32'(c_q8), 32'(m8_cq));
    chk("ov8",   32'(ov8),  32'(m8_v));
    chk("all8",  32'(all8), 32'(m8_cq == 8'hFF));
    chk("any8",  32'(any8), 32'(m8_cq != 8'h00));
    chk("pop8",  32'(pop8), 32'($countones(m8_cq)));
    chk("cnt8",  32'(cnt8), 32'(m8_cnt));
    chk("c_q1",  32'(c_q1), 32'(m1_cq));
    chk("ov1",   32'(ov1),  32'(m1_v));
    chk("all1",  32'(all1), 32'(m1_cq));
    chk("any1",  32'(any1), 32'(m1_cq));
    chk("pop1",  32'(pop1), 32'(m1_cq));
    chk("cnt1",  32'(cnt1), 32'(m1_cnt));
  endtask

  // Drive one cycle, check c in the same timestep, then check registered outputs after the edge.
  task automatic cycle(input logic [7:0] av, input logic [7:0] bv,
                       input logic vld, input logic cl);
    a8 = av; b8 = bv; a1 = av[0]; b1 = bv[0];
    in_valid = vld; clr = cl;
    #1;
    chk("c8_comb", 32'(c8), 32'(av & bv));
    chk("c1_comb", 32'(c1), 32'(av[0] & bv[0]));
    @(posedge clk);
    #1;
    model_step(av, bv, vld, cl);
    check_regs();
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c8;
    logic       c1;
    int         pop8;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 0};
    tbl[1] = '{8'h01, 8'h00, 8'h00, 1'b0, 0};
    tbl[2] = '{8'h00, 8'h01, 8'h00, 1'b0, 0};
    tbl[3] = '{8'h01, 8'h01, 8'h01, 1'b1, 1};
    tbl[4] = '{8'hF0, 8'h3C, 8'h30, 1'b0, 2};
    tbl[5] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 8};
    tbl[6] = '{8'hAA, 8'h55, 8'h00, 1'b0, 0};
    tbl[7] = '{8'hA5, 8'hFF, 8'hA5, 1'b1, 4};

    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0;
    a8 = 8'hF0; b8 = 8'h3C; a1 = 1'b1; b1 = 1'b1;
    model_reset();

    // Reset state; c stays live during reset.
    #12;
    check_regs();
    chk("c8_in_reset", 32'(c8), 32'h30);
    chk("c1_in_reset", 32'(c1), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven: truth table plus WIDTH=8 patterns.
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].a, tbl[i].b, 1'b1, 1'b0);
      chk("tbl_c8",   32'(c8),   32'(tbl[i].c8));
      chk("tbl_c1",   32'(c1),   32'(tbl[i].c1));
      chk("tbl_c_q8", 32'(c_q8), 32'(tbl[i].c8));
      chk("tbl_c_q1", 32'(c_q1), 32'(tbl[i].c1));
      chk("tbl_pop8", 32'(pop8), 32'(tbl[i].pop8));
    end

    // Capture then idle: out_valid drops, data holds.
    cycle(8'hFF, 8'h01, 1'b1, 1'b0);
    chk("cap_ov1", 32'(ov1), 32'h1);
    chk("cap_all1", 32'(all1), 32'h1);
    cycle(8'h00, 8'h00, 1'b0, 1'b0);
    chk("idle_ov1", 32'(ov1), 32'h0);
    chk("idle_c_q1", 32'(c_q1), 32'h1);
    chk("idle_c_q8", 32'(c_q8), 32'h01);

    // Saturation of the 2-bit counter.
    cycle(8'h00, 8'h00, 1'b0, 1'b1);
    chk("clr_cnt8", 32'(cnt8), 32'h0);
    for (int i = 0; i < 5; i++) cycle(8'hFF, 8'hFF, 1'b1, 1'b0);
    chk("sat_cnt8", 32'(cnt8), 32'h3);
    chk("sat_all8", 32'(all8), 32'h1);
    chk("sat_pop8", 32'(pop8), 32'h8);
    // clr beats a simultaneous all-ones capture.
    cycle(8'hFF, 8'hFF, 1'b1, 1'b1);
    chk("clr_prio_cnt8", 32'(cnt8), 32'h0);
    chk("clr_prio_cnt1", 32'(cnt1), 32'h0);
    chk("clr_prio_c_q8", 32'(c_q8), 32'hFF);

    // Asynchronous reset between edges.
    cycle(8'hFF, 8'hFF, 1'b1, 1'b0);
    a8 = 8'hFF; b8 = 8'h0F; in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("arst_c8", 32'(c8), 32'h0F);
    @(posedge clk);
    #1;
    check_regs();
    #3;
    rst_n = 1'b1;
    cycle(8'hFF, 8'hFF, 1'b1, 1'b0);
    chk("post_rst_ov8", 32'(ov8), 32'h1);
    chk("post_rst_cnt8", 32'(cnt8), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra, rb;
      ra = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
      rb = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
      cycle(ra, rb, ($urandom % 4) != 0, ($urandom % 16) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
